// File: rtl/exec_fwd_pkg.sv
// exec_fwd_pkg: shared types and constants for the execute-stage forwarding
// and load-use hazard controller.
//   SEL_*        : operand mux select encodings (register file, stage 1..3)
//   fwd_state_e  : hazard FSM states
//   sb_entry_t   : one in-flight destination tracked by the scoreboard
package exec_fwd_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ST1 = 2'b01;
  localparam logic [1:0] SEL_ST2 = 2'b10;
  localparam logic [1:0] SEL_ST3 = 2'b11;

  // Scoreboard fields are sized for the widest supported configuration:
  // register addresses up to 8 bits, load latency up to 2 (FWD_DEPTH <= 3).
  localparam int SB_RD_W  = 8;
  localparam int SB_CNT_W = 2;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } fwd_state_e;

  typedef struct packed {
    logic                valid;
    logic [SB_RD_W-1:0]  rd;
    logic                is_load;
    logic [SB_CNT_W-1:0] ready_cnt;
  } sb_entry_t;

  // Mux select for downstream stage k (1-based).
  function automatic logic [1:0] stage_sel(input int k);
    case (k)
      1:       return SEL_ST1;
      2:       return SEL_ST2;
      default: return SEL_ST3;
    endcase
  endfunction

endpackage

// File: rtl/exec_fwd_scoreboard_match.sv
// fwd_match: priority match of one source operand against every scoreboard
// entry. The nearest (youngest) matching entry decides the outcome.
//   used, addr : operand read flag and register address
//   entries    : scoreboard, index 0 = stage 1 (youngest)
//   sel        : mux select (SEL_RF when no usable match)
//   hazard     : nearest match is a load whose data is not yet available
module fwd_match
  import exec_fwd_pkg::*;
#(
  parameter int NUM_ENT = 2,
  parameter int REG_AW  = 4,
  parameter int PC_REG  = 15
) (
  input  logic              used,
  input  logic [REG_AW-1:0] addr,
  input  sb_entry_t         entries [NUM_ENT],
  output logic [1:0]        sel,
  output logic              hazard
);

  logic [SB_RD_W-1:0] addr_ext;
  logic               live;

  assign addr_ext = SB_RD_W'(addr);
  // The PC is never forwarded: its value comes from the fetch path.
  assign live     = used && (addr != REG_AW'(PC_REG));

  // Walk from oldest to youngest so the youngest match is the last writer.
  always_comb begin
    sel    = SEL_RF;
    hazard = 1'b0;
    for (int k = NUM_ENT - 1; k >= 0; k--) begin
      if (live && entries[k].valid && (entries[k].rd == addr_ext)) begin
        if (!entries[k].is_load || (entries[k].ready_cnt == '0)) begin
          sel    = stage_sel(k + 1);
          hazard = 1'b0;
        end else begin
          sel    = SEL_RF;
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exec_fwd_scoreboard.sv
// exec_fwd_scoreboard: forwarding and load-use hazard controller for the
// execute stage. Tracks the destinations of the last FWD_DEPTH instructions
// that left execute and picks a forwarding source for each operand.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ex_valid/ex_wr_en : execute holds a real instruction / it writes rd
//   ex_rd, ex_is_load : destination and load flag of the execute instruction
//   src_used/src_addr : per-operand read flag and packed addresses
//   flush             : branch taken, drop the execute instruction
//   sel_src           : per-operand 2-bit mux select
//   stall, bubble     : load-use hold and NOP insertion (combinational)
//   hazard_cnt        : saturating count of stall cycles
//   dbg_state         : hazard FSM state
//
// Handshake: there is none; every output is a same-cycle function of the
// scoreboard and current inputs, and the scoreboard advances every cycle.
module exec_fwd_scoreboard
  import exec_fwd_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = 4,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int PC_REG    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_wr_en,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_is_load,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      sel_src,
  output logic                      stall,
  output logic                      bubble,
  output logic [15:0]               hazard_cnt,
  output fwd_state_e                dbg_state
);

  sb_entry_t          sb [FWD_DEPTH];
  sb_entry_t          sb_new;
  logic [1:0]         raw_sel [NUM_SRC];
  logic [NUM_SRC-1:0] src_haz;
  logic               stall_cond;
  fwd_state_e         state_q, state_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .NUM_ENT (FWD_DEPTH),
      .REG_AW  (REG_AW),
      .PC_REG  (PC_REG)
    ) u_match (
      .used    (src_used[i]),
      .addr    (src_addr[i*REG_AW +: REG_AW]),
      .entries (sb),
      .sel     (raw_sel[i]),
      .hazard  (src_haz[i])
    );
    // A bubble in execute reads nothing, so it never selects a bypass.
    assign sel_src[i*2 +: 2] = ex_valid ? raw_sel[i] : SEL_RF;
  end

  // Flush overrides a hazard: the dependent instruction is being discarded.
  assign stall_cond = (|src_haz) && ex_valid && !flush;
  assign stall      = stall_cond;
  assign bubble     = stall_cond;

  // A stalled or flushed instruction does not advance, so stage 1 gets a hole.
  always_comb begin
    sb_new           = '0;
    sb_new.valid     = ex_valid && ex_wr_en && !stall_cond && !flush;
    sb_new.rd        = SB_RD_W'(ex_rd);
    sb_new.is_load   = ex_is_load;
    sb_new.ready_cnt = SB_CNT_W'(LOAD_LAT);
  end

  function automatic sb_entry_t age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (r.ready_cnt != '0) r.ready_cnt = r.ready_cnt - 1'b1;
    return r;
  endfunction

  // Older entries keep shifting on stall and flush: they are committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FWD_DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[0] <= sb_new;
      for (int k = 1; k < FWD_DEPTH; k++) sb[k] <= age(sb[k-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall_cond)  state_d = LSTALL;
      LSTALL:  if (!stall_cond) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign dbg_state = state_q;

  // Entering or remaining in LSTALL is exactly a stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cnt <= '0;
    end else if ((state_d == LSTALL) && (hazard_cnt != 16'hFFFF)) begin
      hazard_cnt <= hazard_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_exec_fwd_scoreboard.sv
module tb_exec_fwd_scoreboard;
  import exec_fwd_pkg::*;

  localparam int NS = 3;
  localparam int AW = 4;
  localparam int FD = 2;
  localparam int LL = 1;
  localparam int PC = 15;
  localparam int SW = 2 * NS;
  localparam int EW = SW + 19;  // {lstall, cnt[15:0], stall, bubble, sel}

  logic              clk, rst_n;
  logic              ex_valid, ex_wr_en, ex_is_load, flush;
  logic [AW-1:0]     ex_rd;
  logic [NS-1:0]     src_used;
  logic [NS*AW-1:0]  src_addr;
  logic [SW-1:0]     sel_src;
  logic              stall, bubble;
  logic [15:0]       hazard_cnt;
  fwd_state_e        dbg_state;

  int n_cmp, n_bad;
  logic [EW-1:0] exp_q[$];

  // Reference model: history of instructions that left execute, indexed by
  // how many cycles ago they left (1 = last cycle).
  logic          h_v  [1:FD];
  logic [AW-1:0] h_rd [1:FD];
  logic          h_ld [1:FD];
  logic          m_stall;
  logic [15:0]   m_cnt;
  logic          m_lstall;

  exec_fwd_scoreboard #(
    .NUM_SRC(NS), .REG_AW(AW), .FWD_DEPTH(FD), .LOAD_LAT(LL), .PC_REG(PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .src_used(src_used),
    .src_addr(src_addr), .flush(flush), .sel_src(sel_src), .stall(stall),
    .bubble(bubble), .hazard_cnt(hazard_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model update ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 1; a <= FD; a++) begin
        h_v[a]  <= 1'b0;
        h_rd[a] <= '0;
        h_ld[a] <= 1'b0;
      end
      m_cnt    <= '0;
      m_lstall <= 1'b0;
    end else begin
      for (int a = 2; a <= FD; a++) begin
        h_v[a]  <= h_v[a-1];
        h_rd[a] <= h_rd[a-1];
        h_ld[a] <= h_ld[a-1];
      end
      h_v[1]  <= ex_valid && ex_wr_en && !m_stall && !flush;
      h_rd[1] <= ex_rd;
      h_ld[1] <= ex_is_load;
      if (m_stall && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      m_lstall <= m_stall;
    end
  end

  // Load data left execute a cycles ago is usable once a > LOAD_LAT.
  function automatic void model_eval(output logic [SW-1:0] sel, output logic stl);
    logic any, found;
    logic [AW-1:0] ad;
    any = 1'b0;
    sel = '0;
    for (int i = 0; i < NS; i++) begin
      ad = src_addr[i*AW +: AW];
      found = 1'b0;
      if (src_used[i] && ad != AW'(PC)) begin
        for (int a = 1; a <= FD; a++) begin
          if (!found && h_v[a] && h_rd[a] == ad) begin
            found = 1'b1;
            if (!h_ld[a] || a > LL) sel[i*2 +: 2] = 2'(a);
            else any = 1'b1;
          end
        end
      end
    end
    if (!ex_valid) sel = '0;
    stl = any && ex_valid && !flush;
  endfunction

  // ---------------- checking ----------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel_src",    sel_src,            e[SW-1:0]);
      chk("bubble",     bubble,             e[SW]);
      chk("stall",      stall,              e[SW+1]);
      chk("hazard_cnt", hazard_cnt,         e[SW+17:SW+2]);
      chk("state",      dbg_state == LSTALL, e[SW+18]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic wr, input logic [AW-1:0] rd,
                      input logic ld, input logic [NS-1:0] used,
                      input logic [NS*AW-1:0] addr, input logic fl);
    logic [SW-1:0] es;
    logic est;
    @(posedge clk);
    #1;
    ex_valid = v; ex_wr_en = wr; ex_rd = rd; ex_is_load = ld;
    src_used = used; src_addr = addr; flush = fl;
    model_eval(es, est);
    m_stall = est;
    exp_q.push_back({m_lstall, m_cnt, est, est, es});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [NS*AW-1:0] pa(input logic [AW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [AW-1:0] pick_reg();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? AW'(PC) : AW'(r);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; m_stall = 1'b0;
    ex_valid = 0; ex_wr_en = 0; ex_rd = '0; ex_is_load = 0;
    src_used = '0; src_addr = '0; flush = 0;
    #7;
    chk("rst_sel", sel_src, 0);
    chk("rst_stall", stall, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_cnt", hazard_cnt, 0);
    chk("rst_state", dbg_state == LSTALL, 0);
    #5 rst_n = 1'b1;

    // ALU back-to-back
    step(1, 1, 3, 0, 3'b000, '0, 0);
    step(1, 0, 0, 0, 3'b001, pa(3, 0, 0), 0);
    @(negedge clk);
    chk("alu_st1_sel", sel_src, 6'b000001);
    chk("alu_st1_stall", stall, 0);
    step(1, 0, 0, 0, 3'b010, pa(0, 3, 0), 0);
    @(negedge clk);
    chk("alu_st2_sel", sel_src, 6'b001000);

    // load-use
    idle(2);
    step(1, 1, 5, 1, 3'b000, '0, 0);
    step(1, 0, 0, 0, 3'b010, pa(0, 5, 0), 0);
    @(negedge clk);
    chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble, 1);
    chk("lu_state_run", dbg_state == LSTALL, 0);
    step(1, 0, 0, 0, 3'b010, pa(0, 5, 0), 0);
    @(negedge clk);
    chk("lu_release_stall", stall, 0);
    chk("lu_release_sel", sel_src, 6'b001000);
    chk("lu_cnt", hazard_cnt, 1);
    chk("lu_state_lstall", dbg_state == LSTALL, 1);

    // priority: nearest writer wins
    idle(2);
    step(1, 1, 2, 0, 3'b000, '0, 0);
    step(1, 1, 2, 0, 3'b000, '0, 0);
    step(1, 0, 0, 0, 3'b100, pa(0, 0, 2), 0);
    @(negedge clk);
    chk("prio_sel", sel_src, 6'b010000);

    // PC never forwarded, unused operand ignored
    idle(2);
    step(1, 1, 15, 0, 3'b000, '0, 0);
    step(1, 0, 0, 0, 3'b001, pa(15, 0, 0), 0);
    @(negedge clk);
    chk("pc_sel", sel_src, 0);
    chk("pc_stall", stall, 0);
    step(1, 1, 7, 1, 3'b000, '0, 0);
    step(1, 0, 0, 0, 3'b000, pa(7, 7, 7), 0);
    @(negedge clk);
    chk("unused_sel", sel_src, 0);
    chk("unused_stall", stall, 0);

    // flush during hazard
    idle(2);
    step(1, 1, 4, 1, 3'b000, '0, 0);
    step(1, 1, 6, 0, 3'b001, pa(4, 0, 0), 1);
    @(negedge clk);
    chk("flush_stall", stall, 0);
    chk("flush_bubble", bubble, 0);
    step(1, 0, 0, 0, 3'b001, pa(6, 0, 0), 0);
    @(negedge clk);
    chk("flush_state", dbg_state == LSTALL, 0);
    chk("flush_entry1", sel_src, 0);

    // async reset in the middle of a stall
    idle(2);
    step(1, 1, 9, 1, 3'b000, '0, 0);
    step(1, 0, 0, 0, 3'b001, pa(9, 0, 0), 0);
    #2;
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_cnt", hazard_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_bubble", bubble, 0);
    chk("arst_sel", sel_src, 0);
    chk("arst_cnt", hazard_cnt, 0);
    chk("arst_state", dbg_state == LSTALL, 0);
    exp_q.delete();
    ex_valid = 0; ex_wr_en = 0; src_used = '0; flush = 0;
    m_stall = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // randomized traffic; a stalled instruction is usually held in execute
    for (int n = 0; n < 4000; n++) begin
      if (m_stall && $urandom_range(0, 3) != 0) begin
        step(ex_valid, ex_wr_en, ex_rd, ex_is_load, src_used, src_addr,
             ($urandom_range(0, 19) == 0));
      end else begin
        step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), pick_reg(),
             ($urandom_range(0, 9) < 4), NS'($urandom_range(0, (1 << NS) - 1)),
             pa(pick_reg(), pick_reg(), pick_reg()), ($urandom_range(0, 19) == 0));
      end
    end
    idle(1);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_fwd_scoreboard.md
Name: exec_fwd_scoreboard

Overview:
- Parametrised forwarding and load-use hazard controller for the execute stage.
- Generalises the fixed one-stage Rn/Rm/Rs forwarding to NUM_SRC operands and FWD_DEPTH downstream result stages.
- Tracks in-flight destination registers in an internal scoreboard shift pipeline.
- Raises stalls for load-use hazards and drops tracked writes on branch flush.

Parameters:
- NUM_SRC, 3, number of source operands checked (index 0=Rn, 1=Rm, 2=Rs).
- REG_AW, 4, register address width.
- FWD_DEPTH, 2, downstream stages that can forward (1=memory, 2=writeback); legal range 1..3.
- LOAD_LAT, 1, cycles after leaving execute before load data is forwardable; legal range 0..FWD_DEPTH-1.
- PC_REG, 15, register index that is never forwarded or stalled on.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage holds a real instruction (0 = NOP/bubble).
- ex_wr_en  in  1  execute instruction writes a register.
- ex_rd  in  REG_AW  destination of execute instruction.
- ex_is_load  in  1  execute instruction is LDR.
- src_used  in  NUM_SRC  per-operand "operand is read" flags.
- src_addr  in  NUM_SRC*REG_AW  packed operand addresses, operand i at [i*REG_AW +: REG_AW].
- flush  in  1  branch taken; discard younger work.
- sel_src  out  NUM_SRC*2  per-operand mux select: 00 register file, 01 stage 1, 10 stage 2, 11 stage 3.
- stall  out  1  hold fetch/decode/execute this cycle.
- bubble  out  1  execute result must be replaced by NOP downstream.
- hazard_cnt  out  16  saturating count of stall cycles since reset.

Behaviour:
- Scoreboard: FWD_DEPTH entries, each holding {valid, rd, is_load, ready_cnt}.
  - Reset clears all entries.
  - Each cycle, entry k shifts to k+1; the oldest entry is dropped.
  - Entry 1 loads {ex_valid & ex_wr_en & ~stall, ex_rd, ex_is_load, LOAD_LAT}.
  - A stall inserts an invalid entry, i.e. a bubble.
- ready_cnt decrements each cycle while nonzero. An entry is forwardable when valid and ready_cnt==0, or when is_load==0.
- Match for operand i against entry k: src_used[i] & entry.valid & rd==src_addr[i] & src_addr[i]!=PC_REG.
  - Nearest (lowest k) match wins.
  - sel_src[i] = k encoded as 2 bits if that entry is forwardable; otherwise 00.
  - No match gives 00.
  - ex_valid==0 forces all sel_src to 00.
- Hazard: nearest match is a load entry with ready_cnt!=0. Any operand with a hazard asserts stall.
- State machine, two states:
  - RUN to LSTALL when hazard and ex_valid and ~flush.
  - LSTALL holds while hazard persists.
  - LSTALL to RUN when hazard clears.
  - stall and bubble are combinational: asserted in any cycle with hazard & ex_valid & ~flush.
  - The state register feeds hazard_cnt only: increment when state==LSTALL or entering it, saturate at 0xFFFF.
- Flush (same cycle):
  - stall=0, bubble=0.
  - Entry 1 loads invalid.
  - Older entries keep shifting, since they are committed.
  - State goes to RUN.
- Flush and hazard in the same cycle: flush wins.
- LOAD_LAT=0: loads forward like ALU results, and stall never asserts.
- Reset mid-stall: state RUN, entries invalid, all outputs 0, hazard_cnt=0.
- Outputs are combinational from the scoreboard and current inputs. There is zero-cycle latency from src_addr to sel_src.

Decomposition:
- Package exec_fwd_pkg holds:
  - sel_src encodings (SEL_RF, SEL_ST1, SEL_ST2, SEL_ST3).
  - state enum {RUN, LSTALL}.
  - scoreboard entry struct typedef.
- Sub-module fwd_match: one operand's priority match over all entries, producing sel and hazard. Instantiate NUM_SRC times in a generate loop.

Test Plan:
- ALU back-to-back: cycle0 ex writes r3 (non-load); cycle1 operand0=r3 -> sel_src[1:0]=01, stall=0. Cycle2 operand1=r3 -> sel_src[3:2]=10.
- Load-use, LOAD_LAT=1: cycle0 LDR r5; cycle1 operand1=r5 -> stall=1, bubble=1. Cycle2 -> stall=0, sel_src[3:2]=10, hazard_cnt=1.
- Priority: r2 written in two consecutive cycles, then operand2=r2 -> sel_src[5:4]=01, not 10.
- PC / unused operand: operand0=r15 with a pending write to r15 -> sel 00; src_used[0]=0 with a matching rd -> sel 00, no stall.
- Flush during hazard: LDR r4 then operand0=r4 with flush=1 -> stall=0; next cycle entry 1 is invalid and the state is RUN.
- Async reset: assert rst_n=0 mid-LSTALL between clock edges -> stall, sel_src and hazard_cnt go to 0 immediately.
